// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant holding: the owner keeps the resource until done,
// request drop, or the hold limit; every hand-over passes through one dead cycle.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam bit                HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_reg, state_next;
  logic [N-1:0]      grant_reg, grant_next;
  logic              valid_reg, valid_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              timeout_reg, timeout_next;

  // Candidate order for the search: ptr, ptr+1, ... wrapping modulo N.
  logic [ID_W-1:0] cand [N];
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = ID_W'((int'(ptr_reg) + gi) % N);
    end
  endgenerate

  logic            win_found;
  logic [ID_W-1:0] win_id;

  // Walk backwards so the candidate closest to ptr overwrites the others.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        win_found = 1'b1;
        win_id    = cand[k];
      end
    end
  end

  logic rel_done, rel_drop, rel_hold, release_now;

  always_comb begin
    rel_done    = done;
    rel_drop    = !req[id_reg];
    rel_hold    = HOLD_EN && (hold_cnt_reg == HOLD_LAST);
    release_now = rel_done || rel_drop || rel_hold;
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    valid_next    = valid_reg;
    id_next       = id_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE, GAP: begin
        if (win_found) begin
          state_next    = BUSY;
          grant_next    = N'(1) << win_id;
          valid_next    = 1'b1;
          id_next       = win_id;
          hold_cnt_next = '0;
        end else begin
          state_next = IDLE;
          grant_next = '0;
          valid_next = 1'b0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_next   = GAP;
          grant_next   = '0;
          valid_next   = 1'b0;
          ptr_next     = ID_W'((int'(id_reg) + 1) % N);
          // Only a pure hold-limit revocation is reported as a timeout.
          timeout_next = rel_hold && !rel_done && !rel_drop;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      valid_reg    <= 1'b0;
      id_reg       <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      valid_reg    <= valid_next;
      id_reg       <= id_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = valid_reg;
  assign grant_id    = id_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: a cycle model of owner/age/pointer checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rr_hold_arbiter;

  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 16;
  localparam int HOLD_W   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            timeout;

  int checks   = 0;
  int failures = 0;

  rr_hold_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: the resource is either owned (owner >= 0, age = cycles visible so far)
  // or free; a free resource is always offered at the next edge.
  int m_owner, m_age, m_ptr, m_id;
  bit m_to;

  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= -1; m_age <= 0; m_ptr <= 0; m_id <= 0; m_to <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_owner < 0) begin
        if (pick(m_ptr, req) >= 0) begin
          m_owner <= pick(m_ptr, req);
          m_id    <= pick(m_ptr, req);
          m_age   <= 1;
        end
      end else if (done || !req[m_owner] || (MAX_HOLD != 0 && m_age == MAX_HOLD)) begin
        m_to    <= !done && req[m_owner];
        m_ptr   <= (m_owner + 1) % N;
        m_owner <= -1;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("model_id", 32'(grant_id), 32'(m_id));
      chk("model_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(grant_valid), 0);
    chk("rst_id", 32'(grant_id), 0);
    chk("rst_timeout", 32'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;
    do_reset();

    // 1: single requester, done during its third grant cycle
    req = 4'b0001;
    step(1); chk("t1_latency", 32'(grant), 32'b0001); chk("t1_id", 32'(grant_id), 0);
    step(1); chk("t1_hold2", 32'(grant), 32'b0001);
    step(1); chk("t1_hold3", 32'(grant), 32'b0001); done = 1'b1;
    step(1); chk("t1_gap", 32'(grant), 0); chk("t1_gap_valid", 32'(grant_valid), 0);
    done = 1'b0; req = '0;
    step(1); chk("t1_idle", 32'(grant), 0);

    // 2: all requesting, done every second grant cycle
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(1); chk("t2_grant", 32'(grant), 32'd1 << (i % 4));
      step(1); chk("t2_hold", 32'(grant), 32'd1 << (i % 4)); done = 1'b1;
      step(1); chk("t2_gap", 32'(grant), 0); done = 1'b0;
      if (i == 4) req = '0;
    end

    // 3: held request with no done hits the hold limit (ptr is 1 here)
    step(1); chk("t3_idle", 32'(grant), 0);
    req = 4'b0100;
    step(1);
    for (int i = 0; i < 16; i++) begin
      chk("t3_held", 32'(grant), 32'b0100);
      chk("t3_no_to", 32'(timeout), 0);
      step(1);
    end
    chk("t3_revoked", 32'(grant), 0); chk("t3_timeout", 32'(timeout), 1);
    step(1); chk("t3_regrant", 32'(grant), 32'b0100); chk("t3_to_once", 32'(timeout), 0);
    req = '0;
    step(1); chk("t3_drop", 32'(grant), 0); chk("t3_drop_to", 32'(timeout), 0);

    // 4: owner 1 drops while 3 waits; 2 is not requesting and is skipped
    do_reset();
    req = 4'b1010;
    step(1); chk("t4_first", 32'(grant), 32'b0010); chk("t4_first_id", 32'(grant_id), 1);
    step(1); chk("t4_hold", 32'(grant), 32'b0010); req = 4'b1000;
    step(1); chk("t4_gap", 32'(grant), 0); chk("t4_gap_id", 32'(grant_id), 1);
    step(1); chk("t4_next", 32'(grant), 32'b1000); chk("t4_next_id", 32'(grant_id), 3);

    // 5: asynchronous reset in mid-grant, then restart from requester 0's slot
    #2 rst = 1'b1;
    #1;
    chk("t5_async_grant", 32'(grant), 0);
    chk("t5_async_valid", 32'(grant_valid), 0);
    chk("t5_async_to", 32'(timeout), 0);
    req = 4'b1010;
    @(negedge clk); rst = 1'b0;
    step(1); chk("t5_restart", 32'(grant), 32'b0010);

    // 6: done ignored in GAP/IDLE; done coinciding with the hold limit
    step(1); req = '0;
    step(1); chk("t6_gap", 32'(grant), 0); done = 1'b1;
    step(1); chk("t6_idle_done", 32'(grant), 0); chk("t6_idle_to", 32'(timeout), 0);
    step(1); chk("t6_idle_done2", 32'(grant_valid), 0); done = 1'b0;
    req = 4'b0001;
    step(1); chk("t6_wrap", 32'(grant), 32'b0001); chk("t6_wrap_id", 32'(grant_id), 0);
    step(15); chk("t6_age16", 32'(grant), 32'b0001); done = 1'b1;
    step(1); chk("t6_rel", 32'(grant), 0); chk("t6_no_timeout", 32'(timeout), 0);
    done = 1'b0; req = 4'b0010;
    step(1); chk("t6_g1", 32'(grant), 32'b0010);
    step(1); req = '0; done = 1'b1;
    step(1); chk("t6_single_rel", 32'(grant), 0); done = 1'b0;
    step(1); chk("t6_stay_idle", 32'(grant), 0);
    step(1); chk("t6_stay_idle_id", 32'(grant_id), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
